// File: rtl/alu_pkg.sv
// Shared opcode definitions for the ALU, datapath and control unit.
package alu_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [4:0] {
    OP_LD   = 5'b00000,
    OP_LDI  = 5'b00001,
    OP_ST   = 5'b00010,
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_AND  = 5'b00101,
    OP_OR   = 5'b00110,
    OP_SHR  = 5'b00111,
    OP_SHRA = 5'b01000,
    OP_SHL  = 5'b01001,
    OP_ROR  = 5'b01010,
    OP_ROL  = 5'b01011,
    OP_ADDI = 5'b01100,
    OP_ANDI = 5'b01101,
    OP_ORI  = 5'b01110,
    OP_MUL  = 5'b01111,
    OP_DIV  = 5'b10000,
    OP_NEG  = 5'b10001,
    OP_NOT  = 5'b10010,
    OP_BR   = 5'b10011
  } alu_op_e;

endpackage

// File: rtl/reg32.sv
// 32-bit register with load enable and synchronous active-high clear.
module reg32 (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] q
);

  // clear wins over load; otherwise hold unless enabled
  always_ff @(posedge clk) begin
    if (clr)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/alu_unit.sv
// ALU with Y operand register and 64-bit Z result register.
// Optional feature macro: ALU_MULDIV_EN enables signed mul/div; without it
// both opcodes yield zero and no multiplier/divider is built.
module alu_unit
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] bus_in,
  input  logic        Yin,
  input  logic        Zin,
  input  logic [4:0]  operation,
  input  logic        branch_flag,
  output logic [31:0] y_q,
  output logic [31:0] z_hi,
  output logic [31:0] z_lo,
  output logic [63:0] c_out
);

  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  amt;

  assign a   = y_q;
  assign b   = bus_in;
  assign amt = bus_in[4:0];

`ifdef ALU_MULDIV_EN
  logic signed [63:0] product;
  logic signed [31:0] b_safe;
  logic signed [31:0] quotient;
  logic signed [31:0] remainder;

  assign product   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  // divisor forced to 1 on zero so the divider never sees 0; result is overridden below
  assign b_safe    = (b == '0) ? 32'sd1 : $signed(b);
  assign quotient  = $signed(a) / b_safe;
  assign remainder = $signed(a) % b_safe;
`endif

  // combinational result selection
  always_comb begin
    logic [31:0] lo;
    logic [31:0] hi;
    logic [63:0] rot_r;
    logic [63:0] rot_l;
    lo    = '0;
    hi    = '0;
    rot_r = {a, a} >> amt;
    rot_l = {a, a} << amt;
    case (alu_op_e'(operation))
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI: lo = a + b;
      OP_SUB:          lo = a - b;
      OP_AND, OP_ANDI: lo = a & b;
      OP_OR,  OP_ORI:  lo = a | b;
      OP_SHR:          lo = a >> amt;
      OP_SHRA:         lo = $unsigned($signed(a) >>> amt);
      OP_SHL:          lo = a << amt;
      OP_ROR:          lo = rot_r[31:0];
      OP_ROL:          lo = rot_l[63:32];
`ifdef ALU_MULDIV_EN
      OP_MUL: begin
        hi = product[63:32];
        lo = product[31:0];
      end
      OP_DIV: begin
        if (b == '0) begin
          lo = '1;
          hi = a;
        end else begin
          lo = quotient;
          hi = remainder;
        end
      end
`else
      OP_MUL, OP_DIV: lo = '0;
`endif
      OP_NEG:          lo = '0 - b;
      OP_NOT:          lo = ~b;
      OP_BR:           lo = branch_flag ? (a + b) : a;
      default:         lo = b;
    endcase
    c_out = {hi, lo};
  end

  reg32 u_y (
    .clk (clk),
    .clr (clr),
    .en  (Yin),
    .d   (bus_in),
    .q   (y_q)
  );

  reg32 u_z_hi (
    .clk (clk),
    .clr (clr),
    .en  (Zin),
    .d   (c_out[63:32]),
    .q   (z_hi)
  );

  reg32 u_z_lo (
    .clk (clk),
    .clr (clr),
    .en  (Zin),
    .d   (c_out[31:0]),
    .q   (z_lo)
  );

endmodule

// File: tb/tb_alu_unit.sv
// Directed self-checking bench for alu_unit.
module tb_alu_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] bus_in = '0;
  logic        Yin = 1'b0;
  logic        Zin = 1'b0;
  logic [4:0]  operation = '0;
  logic        branch_flag = 1'b0;
  logic [31:0] y_q, z_hi, z_lo;
  logic [63:0] c_out;

  int checks = 0;
  int errors = 0;

  alu_unit dut (
    .clk         (clk),
    .clr         (clr),
    .bus_in      (bus_in),
    .Yin         (Yin),
    .Zin         (Zin),
    .operation   (operation),
    .branch_flag (branch_flag),
    .y_q         (y_q),
    .z_hi        (z_hi),
    .z_lo        (z_lo),
    .c_out       (c_out)
  );

  always #5 clk = ~clk;

  task automatic load_y(input logic [31:0] v);
    @(negedge clk);
    bus_in = v; Yin = 1'b1;
    @(negedge clk);
    Yin = 1'b0;
  endtask

  task automatic exec_op(input logic [4:0] op, input logic [31:0] b, input logic bf);
    @(negedge clk);
    operation = op; bus_in = b; branch_flag = bf; Zin = 1'b1;
    @(negedge clk);
    Zin = 1'b0;
  endtask

  task automatic test_reset;
    clr = 1'b1; Yin = 1'b1; Zin = 1'b1; bus_in = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    clr = 1'b0; Yin = 1'b0; Zin = 1'b0;
    checks++; if (y_q !== 32'h0) begin errors++; $display("FAIL reset_y: got %h expected %h", y_q, 32'h0); end
    checks++; if (z_hi !== 32'h0) begin errors++; $display("FAIL reset_zhi: got %h expected %h", z_hi, 32'h0); end
    checks++; if (z_lo !== 32'h0) begin errors++; $display("FAIL reset_zlo: got %h expected %h", z_lo, 32'h0); end
  endtask

  task automatic test_add;
    load_y(32'h5);
    checks++; if (y_q !== 32'h5) begin errors++; $display("FAIL load_y: got %h expected %h", y_q, 32'h5); end
    exec_op(OP_ADD, 32'h3, 1'b0);
    checks++; if (z_lo !== 32'h8) begin errors++; $display("FAIL add_lo: got %h expected %h", z_lo, 32'h8); end
    checks++; if (z_hi !== 32'h0) begin errors++; $display("FAIL add_hi: got %h expected %h", z_hi, 32'h0); end
    load_y(32'hFFFFFFFF);
    exec_op(OP_ADDI, 32'h1, 1'b0);
    checks++; if ({z_hi, z_lo} !== 64'h0) begin errors++; $display("FAIL add_wrap: got %h expected %h", {z_hi, z_lo}, 64'h0); end
    load_y(32'h3);
    exec_op(OP_SUB, 32'h5, 1'b0);
    checks++; if (z_lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub: got %h expected %h", z_lo, 32'hFFFFFFFE); end
    checks++; if (z_hi !== 32'h0) begin errors++; $display("FAIL sub_hi: got %h expected %h", z_hi, 32'h0); end
  endtask

  task automatic test_logic;
    load_y(32'hF0F0F0F0);
    exec_op(OP_AND, 32'hFF00FF00, 1'b0);
    checks++; if (z_lo !== 32'hF000F000) begin errors++; $display("FAIL and: got %h expected %h", z_lo, 32'hF000F000); end
    exec_op(OP_ORI, 32'hFF00FF00, 1'b0);
    checks++; if (z_lo !== 32'hFFF0FFF0) begin errors++; $display("FAIL ori: got %h expected %h", z_lo, 32'hFFF0FFF0); end
    exec_op(OP_NEG, 32'h1, 1'b0);
    checks++; if (z_lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL neg: got %h expected %h", z_lo, 32'hFFFFFFFF); end
    exec_op(OP_NOT, 32'h0000FFFF, 1'b0);
    checks++; if (z_lo !== 32'hFFFF0000) begin errors++; $display("FAIL not: got %h expected %h", z_lo, 32'hFFFF0000); end
    exec_op(5'b10100, 32'h12345678, 1'b0);
    checks++; if (z_lo !== 32'h12345678) begin errors++; $display("FAIL pass_10100: got %h expected %h", z_lo, 32'h12345678); end
    exec_op(5'b11111, 32'hCAFEF00D, 1'b0);
    checks++; if (z_lo !== 32'hCAFEF00D) begin errors++; $display("FAIL pass_11111: got %h expected %h", z_lo, 32'hCAFEF00D); end
    checks++; if (y_q !== 32'hF0F0F0F0) begin errors++; $display("FAIL y_hold: got %h expected %h", y_q, 32'hF0F0F0F0); end
  endtask

  task automatic test_shift_rotate;
    load_y(32'h80000000);
    exec_op(OP_SHRA, 32'h4, 1'b0);
    checks++; if (z_lo !== 32'hF8000000) begin errors++; $display("FAIL shra: got %h expected %h", z_lo, 32'hF8000000); end
    exec_op(OP_SHR, 32'h4, 1'b0);
    checks++; if (z_lo !== 32'h08000000) begin errors++; $display("FAIL shr: got %h expected %h", z_lo, 32'h08000000); end
    exec_op(OP_ROL, 32'h4, 1'b0);
    checks++; if (z_lo !== 32'h00000008) begin errors++; $display("FAIL rol: got %h expected %h", z_lo, 32'h00000008); end
    exec_op(OP_ROR, 32'h24, 1'b0);  // only B[4:0]=4 counts
    checks++; if (z_lo !== 32'h08000000) begin errors++; $display("FAIL ror_amt: got %h expected %h", z_lo, 32'h08000000); end
    exec_op(OP_ROR, 32'h20, 1'b0);  // amount 0
    checks++; if (z_lo !== 32'h80000000) begin errors++; $display("FAIL ror0: got %h expected %h", z_lo, 32'h80000000); end
    exec_op(OP_SHR, 32'hFFFFFFE1, 1'b0);  // amount 1
    checks++; if (z_lo !== 32'h40000000) begin errors++; $display("FAIL shr_amt: got %h expected %h", z_lo, 32'h40000000); end
    load_y(32'h00000003);
    exec_op(OP_SHL, 32'h1F, 1'b0);
    checks++; if (z_lo !== 32'h80000000) begin errors++; $display("FAIL shl31: got %h expected %h", z_lo, 32'h80000000); end
  endtask

  task automatic test_muldiv;
    logic [31:0] e_hi, e_lo;
    load_y(32'hFFFFFFFE);
    exec_op(OP_MUL, 32'h3, 1'b0);
`ifdef ALU_MULDIV_EN
    e_hi = 32'hFFFFFFFF; e_lo = 32'hFFFFFFFA;
`else
    e_hi = 32'h0; e_lo = 32'h0;
`endif
    checks++; if ({z_hi, z_lo} !== {e_hi, e_lo}) begin errors++; $display("FAIL mul: got %h expected %h", {z_hi, z_lo}, {e_hi, e_lo}); end
    load_y(32'hFFFFFFF9);
    exec_op(OP_DIV, 32'h2, 1'b0);
`ifdef ALU_MULDIV_EN
    e_hi = 32'hFFFFFFFF; e_lo = 32'hFFFFFFFD;
`else
    e_hi = 32'h0; e_lo = 32'h0;
`endif
    checks++; if ({z_hi, z_lo} !== {e_hi, e_lo}) begin errors++; $display("FAIL div: got %h expected %h", {z_hi, z_lo}, {e_hi, e_lo}); end
    load_y(32'h12345678);
    exec_op(OP_DIV, 32'h0, 1'b0);
`ifdef ALU_MULDIV_EN
    e_hi = 32'h12345678; e_lo = 32'hFFFFFFFF;
`else
    e_hi = 32'h0; e_lo = 32'h0;
`endif
    checks++; if ({z_hi, z_lo} !== {e_hi, e_lo}) begin errors++; $display("FAIL div0: got %h expected %h", {z_hi, z_lo}, {e_hi, e_lo}); end
  endtask

  task automatic test_branch;
    load_y(32'h00000100);
    exec_op(OP_BR, 32'h10, 1'b0);
    checks++; if (z_lo !== 32'h00000100) begin errors++; $display("FAIL br0: got %h expected %h", z_lo, 32'h00000100); end
    exec_op(OP_BR, 32'h10, 1'b1);
    checks++; if (z_lo !== 32'h00000110) begin errors++; $display("FAIL br1: got %h expected %h", z_lo, 32'h00000110); end
    // combinational output follows inputs without a clock edge
    @(negedge clk);
    operation = OP_ADD; bus_in = 32'h1; #1;
    checks++; if (c_out !== 64'h0000000000000101) begin errors++; $display("FAIL c_out_comb: got %h expected %h", c_out, 64'h101); end
    checks++; if (z_lo !== 32'h00000110) begin errors++; $display("FAIL z_hold: got %h expected %h", z_lo, 32'h110); end
  endtask

  task automatic test_back_to_back;
    // Y=0x100 from the previous task; simultaneous load sees the old Y
    @(negedge clk);
    operation = OP_ADD; bus_in = 32'h5; Yin = 1'b1; Zin = 1'b1;
    @(negedge clk);
    Yin = 1'b0; Zin = 1'b0;
    checks++; if (z_lo !== 32'h00000105) begin errors++; $display("FAIL yz_same_edge_z: got %h expected %h", z_lo, 32'h105); end
    checks++; if (y_q !== 32'h00000005) begin errors++; $display("FAIL yz_same_edge_y: got %h expected %h", y_q, 32'h5); end
    // clear overrides both loads
    @(negedge clk);
    bus_in = 32'hAAAA5555; Yin = 1'b1; Zin = 1'b1; clr = 1'b1;
    @(negedge clk);
    Yin = 1'b0; Zin = 1'b0; clr = 1'b0;
    checks++; if ({y_q, z_hi, z_lo} !== 96'h0) begin errors++; $display("FAIL clr_override: got %h expected %h", {y_q, z_hi, z_lo}, 96'h0); end
    // registers stay cleared afterwards with no enables
    @(negedge clk);
    checks++; if ({y_q, z_hi, z_lo} !== 96'h0) begin errors++; $display("FAIL clr_hold: got %h expected %h", {y_q, z_hi, z_lo}, 96'h0); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_logic;
    test_shift_rotate;
    test_muldiv;
    test_branch;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port clr, input, 1 bit: reset, synchronous, active-high.
REQ-003 The block SHALL have port bus_in, input, 32 bits: datapath bus value; B operand and Y load data.
REQ-004 The block SHALL have port Yin, input, 1 bit: load enable for the Y (A operand) register.
REQ-005 The block SHALL have port Zin, input, 1 bit: load enable for both Z halves.
REQ-006 The block SHALL have port operation, input, 5 bits: ALU opcode.
REQ-007 The block SHALL have port branch_flag, input, 1 bit: branch-condition result used by the br opcode.
REQ-008 The block SHALL have port y_q, output, 32 bits: Y register contents.
REQ-009 The block SHALL have port z_hi, output, 32 bits: Z register upper word.
REQ-010 The block SHALL have port z_lo, output, 32 bits: Z register lower word.
REQ-011 The block SHALL have port c_out, output, 64 bits: combinational ALU result {hi, lo}.

Function
REQ-012 Operands SHALL be A = y_q and B = bus_in; c_out SHALL be purely combinational from A, B, operation and branch_flag.
REQ-013 The 32-bit result SHALL go in c_out[31:0], with c_out[63:32] = 0, for every opcode except mul and div.
REQ-014 Opcodes 00000 ld, 00001 ldi, 00010 st, 00011 add and 01100 addi SHALL compute A+B modulo 2^32, discarding carry.
REQ-015 Opcode 00100 sub SHALL compute A-B modulo 2^32.
REQ-016 Opcodes 00101 and / 01101 andi SHALL compute A&B; opcodes 00110 or / 01110 ori SHALL compute A|B.
REQ-017 Shift opcodes SHALL use shift amount B[4:0] only. 00111 shr is a logical right shift. 01000 shra is an arithmetic right shift (sign fill). 01001 shl is a logical left shift.
REQ-018 Rotate opcodes SHALL use rotate amount B[4:0]. 01010 ror rotates right; 01011 rol rotates left. An amount of 0 returns A unchanged.
REQ-019 Opcode 01111 mul SHALL compute the signed 32x32 product; c_out[63:32] = high word, c_out[31:0] = low word.
REQ-020 Opcode 10000 div SHALL use signed division truncated toward zero. c_out[31:0] = quotient; c_out[63:32] = remainder, which takes the sign of the dividend A.
REQ-021 For div with B = 0, the quotient SHALL be 0xFFFFFFFF and the remainder SHALL be A.
REQ-022 Opcode 10001 neg SHALL compute 0-B; opcode 10010 not SHALL compute ~B.
REQ-023 Opcode 10011 br SHALL compute A+B when branch_flag = 1 and A otherwise.
REQ-024 All remaining opcodes (10100-11111) SHALL pass B through.
REQ-025 On a rising edge with Yin = 1 and clr = 0, y_q SHALL load bus_in; otherwise y_q holds.
REQ-026 On a rising edge with Zin = 1 and clr = 0, the Z register SHALL capture c_out: z_hi = c_out[63:32], z_lo = c_out[31:0].
REQ-027 When Yin and Zin are both asserted on the same edge, Z SHALL capture the result computed from the pre-edge y_q.
REQ-028 Latency: a Z result SHALL be visible one edge after Zin; y_q SHALL be visible one edge after Yin.

Reset
REQ-029 clr = 1 at a rising edge SHALL clear y_q, z_hi and z_lo to 0x00000000, overriding Yin and Zin.
REQ-030 Asserting clr mid-sequence SHALL discard any pending load; there is no other internal state.

Configuration
REQ-031 With macro ALU_MULDIV_EN defined, mul and div SHALL behave per REQ-019..021.
REQ-032 Without ALU_MULDIV_EN, mul and div SHALL produce c_out = 0, and no multiplier or divider logic is instantiated.

Structure
REQ-033 The 5-bit opcode constants SHALL live in a shared package alu_pkg, which the datapath and control unit also use.
REQ-034 Y, Z_HI and Z_LO SHALL each be an instance of one sub-module, reg32: a 32-bit register with enable and synchronous clear.

Verification
REQ-035 Scenario: load Y = 0x00000005, bus_in = 0x00000003, operation = add, pulse Zin -> z_lo = 0x00000008, z_hi = 0.
REQ-036 Scenario: Y = 0x80000000, bus_in = 4, operations shra, shr and rol -> z_lo = 0xF8000000, 0x08000000 and 0x00000008 respectively.
REQ-037 Scenario (ALU_MULDIV_EN): Y = 0xFFFFFFFE (-2), bus_in = 3, mul -> z_hi = 0xFFFFFFFF, z_lo = 0xFFFFFFFA.
REQ-038 Scenario (ALU_MULDIV_EN): Y = 0xFFFFFFF9 (-7), bus_in = 2, div -> z_lo = 0xFFFFFFFD, z_hi = 0xFFFFFFFF.
REQ-039 Scenario: Y = 0x00000100, bus_in = 0x10, br with branch_flag = 0 -> z_lo = 0x00000100; with branch_flag = 1 -> z_lo = 0x00000110.
REQ-040 Scenario: Yin, Zin and clr all asserted on the same edge -> y_q = z_hi = z_lo = 0; with clr = 0, simultaneous Yin and Zin -> Z reflects the old Y.
